// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the self-clearing register file.
package regfile_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_ADDR_BITS = 5;

  // Register 0 reads as zero and absorbs writes.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    STATE_CLEAR = 1'b0,
    STATE_READY = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then hands the array to
// the normal write port. Also flags writes that arrive while clearing.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 RegWrite,
  output logic                 busy,
  output logic                 ready,
  output logic                 write_dropped,
  output logic                 clear_en,
  output logic [ADDR_BITS-1:0] clear_addr
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

  state_t state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= STATE_CLEAR;
      clear_addr    <= '0;
      busy          <= 1'b1;
      write_dropped <= 1'b0;
    end else begin
      write_dropped <= RegWrite && (state == STATE_CLEAR);
      if (state == STATE_CLEAR) begin
        clear_addr <= clear_addr + 1'b1;
        // Counter wraps to 0 on the same edge that leaves CLEAR.
        if (clear_addr == LAST_ADDR) begin
          state <= STATE_READY;
          busy  <= 1'b0;
        end
      end
    end
  end

  assign ready    = (state == STATE_READY);
  assign clear_en = (state == STATE_CLEAR) && !Reset;

endmodule

// File: rtl/regfile_init.sv
// Two-read/one-write register file with r0 hardwired to zero, a post-reset
// clear sequence (SRAM-style storage, no bulk reset) and optional write bypass.
module regfile_init
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int BYPASS    = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic [ADDR_BITS-1:0] ReadRegister1,
  input  logic [ADDR_BITS-1:0] ReadRegister2,
  input  logic [ADDR_BITS-1:0] WriteRegister,
  input  logic                 RegWrite,
  output logic                 Busy,
  output logic                 WriteDropped
);

  localparam int                   DEPTH  = 1 << ADDR_BITS;
  localparam int                   NPORTS = 2;
  localparam logic [ADDR_BITS-1:0] ZERO_A = ADDR_BITS'(REG_ZERO);

  logic                 busy;
  logic                 ready;
  logic                 clear_en;
  logic [ADDR_BITS-1:0] clear_addr;

  regfile_clear_seq #(
    .ADDR_BITS (ADDR_BITS)
  ) u_clear_seq (
    .Clk           (Clk),
    .Reset         (Reset),
    .RegWrite      (RegWrite),
    .busy          (busy),
    .ready         (ready),
    .write_dropped (WriteDropped),
    .clear_en      (clear_en),
    .clear_addr    (clear_addr)
  );

  assign Busy = busy;

  // Single write port shared between the clear sequencer and the datapath.
  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic [WIDTH-1:0]     wdata;

  always_comb begin
    we    = 1'b0;
    waddr = WriteRegister;
    wdata = WriteData;
    if (clear_en) begin
      we    = 1'b1;
      waddr = clear_addr;
      wdata = '0;
    end else if (ready && !Reset && RegWrite && (WriteRegister != ZERO_A)) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic [NPORTS-1:0][ADDR_BITS-1:0] raddr;
  logic [NPORTS-1:0][WIDTH-1:0]     rdata;

  assign raddr = {ReadRegister2, ReadRegister1};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    logic [WIDTH-1:0] rd;
    always_comb begin
      rd = mem[raddr[p]];
      if ((raddr[p] == ZERO_A) || busy)
        rd = '0;
      else if ((BYPASS != 0) && RegWrite && (WriteRegister == raddr[p]))
        rd = WriteData;
    end
    assign rdata[p] = rd;
  end

  assign ReadData1 = rdata[0];
  assign ReadData2 = rdata[1];

endmodule

// File: tb/tb_regfile_init.sv
// Directed bench for regfile_init: clear sequence, r0, writes, drops, bypass.
module tb_regfile_init;

  localparam int W = 32;
  localparam int A = 5;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [W-1:0] ReadData1, ReadData2, WriteData;
  logic [A-1:0] ReadRegister1, ReadRegister2, WriteRegister;
  logic         RegWrite, Busy, WriteDropped;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_init #(.WIDTH(W), .ADDR_BITS(A), .BYPASS(1)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .RegWrite      (RegWrite),
    .Busy          (Busy),
    .WriteDropped  (WriteDropped)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Count cycles with Busy high, bounded so a stuck Busy cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d);
    RegWrite = 1'b1; WriteRegister = a; WriteData = d;
    step();
    RegWrite = 1'b0;
  endtask

  task automatic rd2(input logic [A-1:0] a1, input logic [A-1:0] a2);
    ReadRegister1 = a1; ReadRegister2 = a2;
    #1;
  endtask

  int n;

  initial begin
    Reset = 1'b1; RegWrite = 1'b0; WriteData = '0; WriteRegister = '0;
    ReadRegister1 = 5'd1; ReadRegister2 = 5'd31;

    // Reset and first clear
    step();
    Reset = 1'b0;
    chk("reset_busy", {31'd0, Busy}, 32'd1);
    chk("reset_drop", {31'd0, WriteDropped}, 32'd0);
    count_busy(n);
    chk("busy_cycles", n, 32);
    rd2(5'd1, 5'd31);
    chk("clr_r1", ReadData1, 32'd0);
    chk("clr_r31", ReadData2, 32'd0);

    // Overwrite same register, both ports
    wr(5'd2, 32'd42);
    rd2(5'd2, 5'd2);
    chk("r2_42_p1", ReadData1, 32'd42);
    chk("r2_42_p2", ReadData2, 32'd42);
    wr(5'd2, 32'd15);
    chk("r2_15_p1", ReadData1, 32'd15);
    chk("r2_15_p2", ReadData2, 32'd15);

    wr(5'd1, 32'd25);
    wr(5'd4, 32'd15);
    rd2(5'd1, 5'd4);
    chk("r1_25", ReadData1, 32'd25);
    chk("r4_15", ReadData2, 32'd15);

    // r0 absorbs writes, not a drop
    rd2(5'd0, 5'd0);
    wr(5'd0, 32'd25);
    chk("r0_p1", ReadData1, 32'd0);
    chk("r0_p2", ReadData2, 32'd0);
    chk("r0_nodrop", {31'd0, WriteDropped}, 32'd0);

    // RegWrite low: no write
    WriteRegister = 5'd5; WriteData = 32'd15; RegWrite = 1'b0;
    step();
    rd2(5'd5, 5'd5);
    chk("r5_nowrite", ReadData1, 32'd0);

    // Bypass: new data visible before the edge
    rd2(5'd3, 5'd3);
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'd7;
    #1;
    chk("bypass_p1", ReadData1, 32'd7);
    chk("bypass_p2", ReadData2, 32'd7);
    step();
    RegWrite = 1'b0;
    #1;
    chk("r3_stored", ReadData1, 32'd7);

    // Reset held with a write pending: no drop, clear restarts
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'd99; Reset = 1'b1;
    step();
    step();
    chk("hold_rst_nodrop", {31'd0, WriteDropped}, 32'd0);
    chk("hold_rst_busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b0; RegWrite = 1'b0;

    // Write during clear is dropped, pulse lasts one cycle
    step();
    rd2(5'd2, 5'd7);
    chk("busy_read_zero", ReadData1, 32'd0);
    wr(5'd7, 32'd99);
    chk("drop_pulse", {31'd0, WriteDropped}, 32'd1);
    step();
    chk("drop_gone", {31'd0, WriteDropped}, 32'd0);
    count_busy(n);
    rd2(5'd7, 5'd2);
    chk("r7_after_drop", ReadData1, 32'd0);
    chk("r2_cleared", ReadData2, 32'd0);

    // Reset mid-clear restarts with a full count
    wr(5'd7, 32'd99);
    rd2(5'd7, 5'd7);
    chk("r7_99", ReadData1, 32'd99);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    count_busy(n);
    chk("restart_cycles", n, 32);
    rd2(5'd7, 5'd7);
    chk("r7_cleared", ReadData1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
